// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op encodings and the FSM state type.
package alu_pkg;

    localparam logic [2:0] OpNeg    = 3'b000;
    localparam logic [2:0] OpInc    = 3'b001;
    localparam logic [2:0] OpAddc   = 3'b010;
    localparam logic [2:0] OpAddSra = 3'b011;
    localparam logic [2:0] OpAnd    = 3'b100;
    localparam logic [2:0] OpOr     = 3'b101;
    localparam logic [2:0] OpCat    = 3'b110;
    localparam logic [2:0] OpZero   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; results wrap modulo 2^WIDTH.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    logic signed [WIDTH-1:0] b_s;
    assign b_s = b;

    always_comb begin
        result = '0;
        unique case (op)
            OpNeg:    result = ~a + WIDTH'(1);
            OpInc:    result = a + WIDTH'(1);
            OpAddc:   result = a + b + WIDTH'(c);
            OpAddSra: result = a + $unsigned(b_s >>> 1);
            OpAnd:    result = a & b;
            OpOr:     result = a | b;
            OpCat:    result = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
            OpZero:   result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; one operation in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_c,
    input  logic             req1_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_port,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             busy,
    output logic [15:0]      op_count
);

    state_e             state_q, state_d;
    logic               last_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               c_q, port_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_zero_q, rsp_neg_q, rsp_port_q;
    logic [15:0]        op_count_q;

    logic               grant, accept;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_zero, alu_neg;

    // Tie goes to the port not served last; a lone requester wins outright.
    assign grant  = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
    assign accept = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .result (alu_result),
        .zero   (alu_zero),
        .neg    (alu_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            port_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_neg_q  <= 1'b0;
            rsp_port_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= grant;
                port_q <= grant;
                op_q   <= grant ? req1_op : req0_op;
                a_q    <= grant ? req1_a  : req0_a;
                b_q    <= grant ? req1_b  : req0_b;
                c_q    <= grant ? req1_c  : req0_c;
            end
            if (state_q == StExec) begin
                rsp_data_q <= alu_result;
                rsp_zero_q <= alu_zero;
                rsp_neg_q  <= alu_neg;
                rsp_port_q <= port_q;
            end
            if (state_q == StResp && rsp_ready && op_count_q != 16'hFFFF) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_port  = rsp_port_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_neg   = rsp_neg_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model checked every cycle.
module tb_alu_arbiter;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]     req0_op, req1_op;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_c, req1_c;
    logic           rsp_valid, rsp_ready, rsp_port, rsp_zero, rsp_neg, busy;
    logic [W-1:0]   rsp_data;
    logic [15:0]    op_count;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int accept_cyc = 0;

    alu_arbiter #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_c     (req0_c),
        .req1_c     (req1_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_port   (rsp_port),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic c);
        int ai, bi, r;
        ai = int'($signed(a));
        bi = int'($signed(b));
        case (op)
            3'd0:    r = -ai;
            3'd1:    r = ai + 1;
            3'd2:    r = ai + bi + int'(c);
            3'd3:    r = ai + (bi - (bi & 1)) / 2;
            3'd4:    r = int'(a & b);
            3'd5:    r = int'(a | b);
            3'd6:    r = ((int'(a) & 255) << 8) | (int'(b) & 255);
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    // Model: at most one op outstanding; age 0 = computing, age >= 1 = response offered.
    bit          m_have, m_last, m_pport, m_port, m_zero, m_neg;
    int          m_age, m_count;
    logic [15:0] m_pend, m_data;

    always @(negedge clk) begin
        bit any, g, e0, e1;
        if (!rst_n) begin
            m_have = 0; m_age = 0; m_last = 1; m_count = 0;
            m_data = '0; m_port = 0; m_zero = 0; m_neg = 0;
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_op_count", op_count, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_flags", {rsp_port, rsp_zero, rsp_neg}, 0);
        end else begin
            any = req0_valid || req1_valid;
            g   = (req0_valid && req1_valid) ? !m_last : !req0_valid;
            e0  = !m_have && any && !g;
            e1  = !m_have && any && g;
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("rsp_valid", rsp_valid, m_have && m_age >= 1);
            chk("busy", busy, m_have);
            chk("op_count", op_count, m_count);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_port", rsp_port, m_port);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_neg", rsp_neg, m_neg);
            if (!m_have && any) begin
                m_have = 1; m_age = 0; m_last = g; m_pport = g;
                m_pend = g ? alu_model(req1_op, req1_a, req1_b, req1_c)
                           : alu_model(req0_op, req0_a, req0_b, req0_c);
            end else if (m_have && m_age == 0) begin
                m_age = 1; m_data = m_pend; m_port = m_pport;
                m_zero = (m_pend == 16'h0); m_neg = m_pend[15];
            end else if (m_have && rsp_ready) begin
                m_have = 0;
                if (m_count < 65535) m_count++;
            end
        end
    end

    task automatic wait_accept(input bit p);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                got = 1;
                accept_cyc = cyc;
            end
        end
        chk("accept", got, 1);
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; the pending result must not move.
        if (!p) begin
            req0_valid = 0; req0_op = 3'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
        end else begin
            req1_valid = 0; req1_op = 3'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
        end
    endtask

    task automatic send(input bit p, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
        @(posedge clk);
        #1;
        if (!p) begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_c = c;
        end else begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_c = c;
        end
        wait_accept(p);
    endtask

    task automatic wait_rsp(input string nm, input logic [15:0] d, input bit z, input bit n,
                            input bit p);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk({nm, "_seen"}, got, 1);
        chk({nm, "_latency"}, cyc - accept_cyc, 2);
        chk({nm, "_data"}, rsp_data, d);
        chk({nm, "_zero"}, rsp_zero, z);
        chk({nm, "_neg"}, rsp_neg, n);
        chk({nm, "_port"}, rsp_port, p);
    endtask

    initial begin
        int gseen [4];
        int ng;
        bit done;

        req0_valid = 0; req1_valid = 0; req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_c = 0; req1_c = 0;
        rsp_ready = 1;

        chk("model_addc", alu_model(3'd2, 16'h7FFF, 16'h0001, 1'b0), 16'h8000);
        chk("model_neg", alu_model(3'd0, 16'h0001, 16'h0000, 1'b0), 16'hFFFF);
        chk("model_sra", alu_model(3'd3, 16'h0000, 16'hFFF0, 1'b0), 16'hFFF8);
        chk("model_sra_odd", alu_model(3'd3, 16'h0001, 16'hFFFF, 1'b0), 16'h0000);
        chk("model_cat", alu_model(3'd6, 16'h12AB, 16'h34CD, 1'b0), 16'hABCD);

        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1;

        send(0, 3'b010, 16'h7FFF, 16'h0001, 1'b0);
        wait_rsp("addc", 16'h8000, 0, 1, 0);

        send(1, 3'b000, 16'h0000, 16'h5555, 1'b0);
        wait_rsp("neg_zero", 16'h0000, 1, 0, 1);
        send(1, 3'b110, 16'h12AB, 16'h34CD, 1'b0);
        wait_rsp("cat", 16'hABCD, 0, 1, 1);

        send(0, 3'b011, 16'h0000, 16'hFFF0, 1'b0);
        wait_rsp("sra", 16'hFFF8, 0, 1, 0);
        send(1, 3'b111, 16'h1234, 16'h5678, 1'b1);
        wait_rsp("op_zero", 16'h0000, 1, 0, 1);

        // Stall the consumer while the other port keeps asking.
        @(posedge clk);
        #1 rsp_ready = 0;
        send(0, 3'b001, 16'h0005, 16'h0000, 1'b0);
        req1_valid = 1; req1_op = 3'b100; req1_a = 16'hF0F0; req1_b = 16'hFF00; req1_c = 0;
        wait_rsp("stall", 16'h0006, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 16'h0006);
            chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk);
        #1 rsp_ready = 1;
        wait_accept(1);
        wait_rsp("after_stall", 16'hF000, 0, 1, 1);

        // Fresh reset, then both ports contend continuously.
        @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        req0_valid = 1; req0_op = 3'b101; req0_a = 16'h00F0; req0_b = 16'h0F00; req0_c = 0;
        req1_valid = 1; req1_op = 3'b001; req1_a = 16'h7FFF; req1_b = 16'h0000; req1_c = 0;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (req0_ready) begin gseen[ng] = 0; ng++; end
            else if (req1_ready) begin gseen[ng] = 1; ng++; end
        end
        @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        chk("rr_grants", ng, 4);
        chk("rr_order", {gseen[0][0], gseen[1][0], gseen[2][0], gseen[3][0]}, 4'b0101);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (op_count == 16'd4 && !busy) done = 1;
        end
        chk("rr_op_count", op_count, 16'd4);

        // Reset while the op is computing: it must vanish and the pointer restart at port 0.
        send(0, 3'b001, 16'h0001, 16'h0000, 1'b0);
        rst_n = 0;
        req0_valid = 1; req0_op = 3'b010; req0_a = 16'h0001; req0_b = 16'h0002; req0_c = 1;
        req1_valid = 1; req1_op = 3'b111; req1_a = 16'h0000; req1_b = 16'h0000; req1_c = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("exec_rst_valid", rsp_valid, 0);
            chk("exec_rst_count", op_count, 16'd0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_tie", {req0_ready, req1_ready}, 2'b10);
        accept_cyc = cyc;
        @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        wait_rsp("post_rst", 16'h0004, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_count", op_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
